noc_rx_checker: RTL
===================

# noc_rx_checker

Receive-side endpoint for a 2x2 mesh NoC port: accepts 16-bit flits from a router output using the same write/full/almost_full flow control that processing elements use to inject traffic, buffers them in a small FIFO, and drains them one per cycle when enabled. Each drained flit is decoded and checked for the valid marker, correct destination and per-source sequence continuity. It forms the consumer half of each node and serves as a self-checking sink in NoC benches.

## Interface
- ID, 0: this node's 4-bit destination address, compared against flit dest field.
- DEPTH, 4: FIFO entries, power of two, at least 2.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- write  input  1  router delivers dataIn this cycle.
- dataIn  input  16  flit: [15:7] seq, [6:5] src, [4:1] dest, [0] valid marker.
- full  output  1  registered, FIFO holds DEPTH entries.
- almost_full  output  1  registered, FIFO holds at least DEPTH-1 entries.
- enable  input  1  drain permission; one flit popped per enabled cycle when non-empty.
- out_valid  output  1  one-cycle pulse, decoded flit presented.
- out_src  output  2  source of presented flit.
- out_seq  output  9  sequence of presented flit.
- rx_count  output  16  flits checked, wraps.
- err_mark  output  1  sticky: flit with bit 0 = 0 checked.
- err_dest  output  1  sticky: dest field != ID.
- err_seq  output  1  sticky: sequence discontinuity.
- err_ovf  output  1  sticky: write while full.

## Operation
- Reset: FIFO empty, pointers 0, full=0, almost_full=0, out_valid=0, out_src=0, out_seq=0, rx_count=0, all err flags 0, all per-source seen bits 0, expected seq 0.
- Accept: write with occupancy < DEPTH stores dataIn at tail. Write while full: flit discarded, err_ovf set, occupancy unchanged.
- Flags track post-update occupancy: almost_full when occupancy >= DEPTH-1, full when occupancy == DEPTH. Sender rule: stop when (previous write and almost_full) or (no previous write and full); a compliant sender never overflows.
- Simultaneous push and pop: both take effect, occupancy unchanged; permitted when full (pop frees slot same cycle).
- Pop: enable with occupancy > 0 moves head into check register (stage 1).
- Check (stage 2), on flit in check register: out_valid=1, out_src/out_seq loaded, rx_count+1; bit0==0 sets err_mark; dest != ID sets err_dest; sequence check below. All checks evaluated independently on the same flit.
- Sequence check per src s (4 entries): if seen[s]==0, set seen[s], expected[s]=seq+1, no error. Else if seq != expected[s], set err_seq and resync expected[s]=seq+1; else expected[s]=seq+1. 9-bit arithmetic, 511 -> 0 wrap is continuous.
- Error flags clear only on reset.
- Reset mid-operation: buffered and in-flight flits lost, no out_valid after reset release until new traffic.

## Timing
- write sampled at edge N: occupancy and flags updated at N; visible to sender in cycle N+1.
- Pop at edge N (enable=1, non-empty): out_valid and fields valid after edge N+1; error flags and rx_count updated at same edge N+1.
- Minimum write-to-out_valid latency: 3 edges (store, pop, check) with enable held high.
- Sustained throughput: one flit per cycle with continuous write and enable.
- enable=0: no pop, out_valid=0 next cycle, FIFO fills.

## Configuration
- NOC_RX_SEQCHK_EN defined: per-source seen/expected registers and sequence check present as described.
- Undefined: seen/expected registers not instantiated, err_seq tied 0; all other behaviour identical.

## Test plan
- Reset then 4 writes (dest=ID, src=1, seq 0..3, bit0=1), enable=1 -> four out_valid pulses, out_seq 0,1,2,3, rx_count=4, all err flags 0.
- enable=0, DEPTH=4, writes on 4 consecutive cycles -> almost_full after 3rd, full after 4th; 5th write -> err_ovf=1, subsequent drain yields only first 4 flits.
- Full FIFO, write and enable same cycle -> no err_ovf, occupancy stays 4, new flit drained in order.
- src=2 seq 510, 511, 0, then 5 -> err_seq stays 0 through 0, sets on 5; next seq 6 -> no further change, expected resynced (with NOC_RX_SEQCHK_EN; without, err_seq stays 0).
- Flit with dest=ID+1 and flit with bit0=0 -> err_dest=1 and err_mark=1 respectively, both still counted in rx_count and presented on out_*.
- Assert reset with 3 flits buffered -> full=0, almost_full=0, rx_count=0, no out_valid after release.

Source files
------------

// File: rtl/noc_rx_checker.sv
// noc_rx_checker: NoC receive endpoint; FIFO buffering plus drained-flit marker/dest/sequence checks.
// Optional macro NOC_RX_SEQCHK_EN adds per-source sequence continuity checking (err_seq).
module noc_rx_checker #(
    parameter logic [3:0] ID    = 4'd0,
    parameter int         DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] dataIn,
    output logic        full,
    output logic        almost_full,
    input  logic        enable,
    output logic        out_valid,
    output logic [1:0]  out_src,
    output logic [8:0]  out_seq,
    output logic [15:0] rx_count,
    output logic        err_mark,
    output logic        err_dest,
    output logic        err_seq,
    output logic        err_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_afull;
    logic          r_chk_v;
    logic [15:0]   r_chk;
    logic          r_out_v;
    logic [1:0]    r_out_src;
    logic [8:0]    r_out_seq;
    logic [15:0]   r_rx_count;
    logic          r_err_mark, r_err_dest, r_err_ovf;
    logic          w_pop, w_push, w_ovf;
    logic [CW-1:0] w_count_nxt;
    logic [1:0]    w_src;
    logic [8:0]    w_seq;

    // A pop in the same cycle frees a slot, so a write to a full FIFO is accepted then.
    assign w_pop       = enable && (r_count != '0);
    assign w_push      = write && (!r_full || w_pop);
    assign w_ovf       = write && r_full && !w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_src       = r_chk[6:5];
    assign w_seq       = r_chk[15:7];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= dataIn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_chk_v <= 1'b0;
            r_chk   <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= w_count_nxt;
            r_full  <= w_count_nxt == CW'(DEPTH);
            r_afull <= w_count_nxt >= CW'(DEPTH - 1);
            r_chk_v <= w_pop;
            if (w_pop) r_chk <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_v    <= 1'b0;
            r_out_src  <= '0;
            r_out_seq  <= '0;
            r_rx_count <= '0;
            r_err_mark <= 1'b0;
            r_err_dest <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_out_v   <= r_chk_v;
            r_err_ovf <= r_err_ovf | w_ovf;
            if (r_chk_v) begin
                r_out_src  <= w_src;
                r_out_seq  <= w_seq;
                r_rx_count <= r_rx_count + 16'd1;
                r_err_mark <= r_err_mark | ~r_chk[0];
                r_err_dest <= r_err_dest | (r_chk[4:1] != ID);
            end
        end
    end

`ifdef NOC_RX_SEQCHK_EN
    logic [3:0] r_seen;
    logic [8:0] r_exp [4];
    logic       r_err_seq;

    // First flit from a source only arms its expectation; later gaps resync to the observed seq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen    <= '0;
            r_err_seq <= 1'b0;
            for (int i = 0; i < 4; i++) r_exp[i] <= '0;
        end else if (r_chk_v) begin
            r_seen[w_src] <= 1'b1;
            r_exp[w_src]  <= w_seq + 9'd1;
            if (r_seen[w_src] && (w_seq != r_exp[w_src])) r_err_seq <= 1'b1;
        end
    end

    assign err_seq = r_err_seq;
`else
    assign err_seq = 1'b0;
`endif

    assign full        = r_full;
    assign almost_full = r_afull;
    assign out_valid   = r_out_v;
    assign out_src     = r_out_src;
    assign out_seq     = r_out_seq;
    assign rx_count    = r_rx_count;
    assign err_mark    = r_err_mark;
    assign err_dest    = r_err_dest;
    assign err_ovf     = r_err_ovf;
endmodule
